// File: rtl/lif_layer_scheduler.sv
// lif_layer_scheduler
// One shared leaky-integrate-and-fire update datapath, swept across N_NEURON
// neurons (one per clock) on each accepted timestep start. Membrane values,
// fired flags and 2-bit synaptic weights are held per neuron. The spike
// vector of a sweep is staged internally and published in one shot at the
// end, so downstream logic never sees a half-updated vector.
module lif_layer_scheduler #(
  parameter int N_NEURON = 8,
  parameter int AW       = $clog2(N_NEURON),
  parameter int VW       = 5,
  parameter int V_REST   = 6,
  parameter int V_LEAK   = 1,
  parameter int V_TH     = 14
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [2:0]          spikes_in_i,
  input  logic                cfg_we_i,
  input  logic [AW-1:0]       cfg_addr_i,
  input  logic [5:0]          cfg_w_i,
  output logic                cfg_err_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [N_NEURON-1:0] spike_vec_o,
  output logic [15:0]         step_cnt_o
);

  typedef enum logic {IDLE, RUN} state_e;

  // The update arithmetic runs two bits wider than the membrane so that
  // v + sum (up to 2^VW-1 + 9) never wraps before saturation.
  localparam int XW = VW + 2;

  localparam logic [AW-1:0] IDX_LAST = AW'(N_NEURON - 1);
  localparam logic [AW:0]   N_LIM    = (AW + 1)'(N_NEURON);
  localparam logic [VW-1:0] V_REST_V = VW'(V_REST);
  localparam logic [XW-1:0] V_LEAK_X = XW'(V_LEAK);
  localparam logic [XW-1:0] V_TH_X   = XW'(V_TH);
  localparam logic [XW-1:0] V_MAX_X  = XW'((1 << VW) - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [2:0]          s_q, s_d;
  logic [VW-1:0]       v_q [N_NEURON];
  logic [VW-1:0]       v_d [N_NEURON];
  logic                f_q [N_NEURON];
  logic                f_d [N_NEURON];
  logic [5:0]          w_q [N_NEURON];
  logic [5:0]          w_d [N_NEURON];
  logic [N_NEURON-1:0] stage_q, stage_d;
  logic [N_NEURON-1:0] spike_vec_q, spike_vec_d;
  logic [15:0]         step_cnt_q, step_cnt_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;

  logic [VW-1:0] v_cur;
  logic          f_cur;
  logic [5:0]    w_cur;
  logic [XW-1:0] sum_x;
  logic [XW-1:0] vn_x;
  logic [VW-1:0] vn;
  logic          fire;
  logic          cfg_ok;

  // Membrane update for the neuron currently addressed by the sweep index.
  always_comb begin
    v_cur = v_q[idx_q];
    f_cur = f_q[idx_q];
    w_cur = w_q[idx_q];
    sum_x = XW'(w_cur[1:0] & {2{s_q[0]}})
          + XW'(w_cur[3:2] & {2{s_q[1]}})
          + XW'(w_cur[5:4] & {2{s_q[2]}});
    vn_x  = {2'b00, v_cur} + sum_x;
    // Leak only above rest, so the subtraction can never underflow.
    if (v_cur > V_REST_V) begin
      vn_x = vn_x - V_LEAK_X;
    end
    vn   = (vn_x > V_MAX_X) ? V_MAX_X[VW-1:0] : vn_x[VW-1:0];
    fire = ({2'b00, vn} >= V_TH_X);
  end

  // Next-state: FSM sequencing, per-neuron writeback, config port, publishing.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    s_d         = s_q;
    v_d         = v_q;
    f_d         = f_q;
    w_d         = w_q;
    stage_d     = stage_q;
    spike_vec_d = spike_vec_q;
    step_cnt_d  = step_cnt_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    // Weights only change between sweeps; a write landing on the accepting
    // edge is in place before neuron 0 is read at the following edge.
    cfg_ok = (state_q == IDLE) && ({1'b0, cfg_addr_i} < N_LIM);
    if (cfg_we_i) begin
      if (cfg_ok) begin
        w_d[cfg_addr_i] = cfg_w_i;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          idx_d   = '0;
          s_d     = spikes_in_i;
        end
      end
      RUN: begin
        // A neuron that fired last step is silenced and returned to rest.
        if (f_cur) begin
          v_d[idx_q]     = V_REST_V;
          f_d[idx_q]     = 1'b0;
          stage_d[idx_q] = 1'b0;
        end else begin
          v_d[idx_q]     = vn;
          f_d[idx_q]     = fire;
          stage_d[idx_q] = fire;
        end
        if (idx_q == IDX_LAST) begin
          state_d     = IDLE;
          idx_d       = '0;
          spike_vec_d = stage_d;
          step_cnt_d  = step_cnt_q + 16'd1;
          done_d      = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and per-neuron storage registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      s_q         <= '0;
      stage_q     <= '0;
      spike_vec_q <= '0;
      step_cnt_q  <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      // NOTE: the per-neuron arrays are reset explicitly because membranes
      // must restart at rest and weights at zero; a plain RAM would not.
      for (int i = 0; i < N_NEURON; i++) begin
        v_q[i] <= V_REST_V;
        f_q[i] <= 1'b0;
        w_q[i] <= '0;
      end
    end else begin
      idx_q       <= idx_d;
      s_q         <= s_d;
      stage_q     <= stage_d;
      spike_vec_q <= spike_vec_d;
      step_cnt_q  <= step_cnt_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      for (int i = 0; i < N_NEURON; i++) begin
        v_q[i] <= v_d[i];
        f_q[i] <= f_d[i];
        w_q[i] <= w_d[i];
      end
    end
  end

  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;
  assign cfg_err_o   = cfg_err_q;
  assign spike_vec_o = spike_vec_q;
  assign step_cnt_o  = step_cnt_q;

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Testbench for lif_layer_scheduler: hand-derived vector tables for the
// single-neuron scenarios, hand-written protocol sequences, and a randomized
// run checked against a timestep-level behavioural model.
// A non-power-of-two neuron count makes out-of-range config addresses
// (N_NEURON and above) representable on the AW-bit address port.
module tb_lif_layer_scheduler;

  localparam int N      = 6;
  localparam int AW     = $clog2(N);
  localparam int V_REST = 6;
  localparam int V_LEAK = 1;
  localparam int V_TH   = 14;
  localparam int V_MAX  = 31;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [2:0]    spikes_in_i = '0;
  logic          cfg_we_i = 1'b0;
  logic [AW-1:0] cfg_addr_i = '0;
  logic [5:0]    cfg_w_i = '0;
  logic          cfg_err_o;
  logic          busy_o;
  logic          done_o;
  logic [N-1:0]  spike_vec_o;
  logic [15:0]   step_cnt_o;

  lif_layer_scheduler #(.N_NEURON(N)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .spikes_in_i (spikes_in_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_w_i     (cfg_w_i),
    .cfg_err_o   (cfg_err_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .spike_vec_o (spike_vec_o),
    .step_cnt_o  (step_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: one call = one whole timestep over all neurons.
  int           mv [N];
  int           mf [N];
  int           mw [N][3];
  int           mcnt;
  logic [N-1:0] m_vec;

  typedef struct {
    logic [2:0]   s;
    logic [N-1:0] exp_vec;
    logic [15:0]  exp_cnt;
  } vec_t;

  vec_t tab_a [4];
  vec_t tab_b [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = V_REST;
      mf[i] = 0;
      for (int j = 0; j < 3; j++) mw[i][j] = 0;
    end
    mcnt  = 0;
    m_vec = '0;
  endtask

  task automatic model_cfg(input int a, input logic [5:0] w);
    mw[a][0] = int'(w[1:0]);
    mw[a][1] = int'(w[3:2]);
    mw[a][2] = int'(w[5:4]);
  endtask

  task automatic model_step(input logic [2:0] s);
    int sum;
    int vn;
    for (int i = 0; i < N; i++) begin
      if (mf[i] != 0) begin
        mv[i]    = V_REST;
        mf[i]    = 0;
        m_vec[i] = 1'b0;
      end else begin
        sum = mw[i][0] * int'(s[0]) + mw[i][1] * int'(s[1]) + mw[i][2] * int'(s[2]);
        vn  = mv[i] + sum - ((mv[i] > V_REST) ? V_LEAK : 0);
        if (vn > V_MAX) vn = V_MAX;
        mv[i]    = vn;
        mf[i]    = (vn >= V_TH) ? 1 : 0;
        m_vec[i] = (vn >= V_TH);
      end
    end
    mcnt = (mcnt + 1) % 65536;
  endtask

  // Called at #1 after a clock edge; leaves the bench at the same phase.
  task automatic do_reset();
    rst_n       = 1'b0;
    start_i     = 1'b0;
    cfg_we_i    = 1'b0;
    spikes_in_i = '0;
    model_reset();
    #1;
    check("rst_busy",    busy_o,      0);
    check("rst_done",    done_o,      0);
    check("rst_cfg_err", cfg_err_o,   0);
    check("rst_vec",     spike_vec_o, 0);
    check("rst_cnt",     step_cnt_o,  0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [5:0] w);
    bit bad;
    bad        = (a >= N);
    cfg_we_i   = 1'b1;
    cfg_addr_i = AW'(a);
    cfg_w_i    = w;
    @(posedge clk_i);
    #1;
    cfg_we_i = 1'b0;
    check("cfg_err", cfg_err_o, {31'b0, bad});
    if (!bad) model_cfg(a, w);
    @(posedge clk_i);
    #1;
    check("cfg_err_clear", cfg_err_o, 0);
  endtask

  // One timestep. poke: during RUN attempt a config write to neuron 0 and
  // raise start (both must be ignored). cfg_same: config write on the
  // accepting edge.
  task automatic sweep(input logic [2:0] s, input bit poke, input bit cfg_same,
                       input int caddr, input logic [5:0] cw);
    start_i     = 1'b1;
    spikes_in_i = s;
    if (cfg_same) begin
      cfg_we_i   = 1'b1;
      cfg_addr_i = AW'(caddr);
      cfg_w_i    = cw;
    end
    @(posedge clk_i);
    #1;
    start_i  = 1'b0;
    cfg_we_i = 1'b0;
    if (cfg_same) begin
      check("cfg_same_err", cfg_err_o, 0);
      model_cfg(caddr, cw);
    end
    check("t0_busy", busy_o, 1);
    check("t0_done", done_o, 0);
    if (poke) begin
      cfg_we_i   = 1'b1;
      cfg_addr_i = '0;
      cfg_w_i    = 6'h3F;
      start_i    = 1'b1;
    end
    for (int k = 1; k <= N; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 1 && poke) begin
        check("run_cfg_err", cfg_err_o, 1);
        cfg_we_i = 1'b0;
        start_i  = 1'b0;
      end
      if (k < N) begin
        check("run_busy", busy_o, 1);
        check("run_vec_hold", spike_vec_o, m_vec);
      end
    end
    model_step(s);
    check("tn_done", done_o,      1);
    check("tn_busy", busy_o,      0);
    check("tn_vec",  spike_vec_o, m_vec);
    check("tn_cnt",  step_cnt_o,  mcnt);
    @(posedge clk_i);
    #1;
    check("post_done", done_o, 0);
    check("post_busy", busy_o, 0);
  endtask

  initial begin
    int c;
    int dcount;
    int t_prev;

    // Neuron 0 {3,3,3}, all inputs spiking: v 15,6,15,6.
    tab_a[0] = '{3'b111, 6'b000001, 16'd1};
    tab_a[1] = '{3'b111, 6'b000000, 16'd2};
    tab_a[2] = '{3'b111, 6'b000001, 16'd3};
    tab_a[3] = '{3'b111, 6'b000000, 16'd4};
    // Neuron 1 w1=2 climbs 8..14 and fires at step 7; neuron 2 w1=1 sits at 7.
    for (int i = 0; i < 8; i++) tab_b[i] = '{3'b001, 6'b000000, 16'(i + 1)};
    tab_b[6].exp_vec = 6'b000010;

    @(posedge clk_i);
    #1;
    do_reset();

    // Weights zero: one sweep, nothing fires, counter advances to 1.
    sweep(3'b111, 0, 0, 0, 6'h00);
    check("zero_w_vec", spike_vec_o, 0);
    check("zero_w_cnt", step_cnt_o,  1);

    // Table A.
    do_reset();
    cfg_write(0, 6'h3F);
    for (int i = 0; i < 4; i++) begin
      sweep(tab_a[i].s, 0, 0, 0, 6'h00);
      check("tabA_vec", spike_vec_o, tab_a[i].exp_vec);
      check("tabA_cnt", step_cnt_o,  tab_a[i].exp_cnt);
    end

    // Table B, then neuron 2 must stay silent out to 50 steps.
    do_reset();
    cfg_write(1, 6'b000010);
    cfg_write(2, 6'b000001);
    for (int i = 0; i < 8; i++) begin
      sweep(tab_b[i].s, 0, 0, 0, 6'h00);
      check("tabB_vec", spike_vec_o, tab_b[i].exp_vec);
      check("tabB_cnt", step_cnt_o,  tab_b[i].exp_cnt);
    end
    for (int i = 8; i < 50; i++) begin
      sweep(3'b001, 0, 0, 0, 6'h00);
      check("n2_silent", spike_vec_o[2], 0);
    end

    // Protocol: rejected writes during RUN and at address N / N+1.
    do_reset();
    sweep(3'b111, 1, 0, 0, 6'h00);
    check("poke_no_fire", spike_vec_o[0], 0);
    cfg_write(N, 6'h3F);
    cfg_write(N + 1, 6'h3F);
    sweep(3'b111, 0, 0, 0, 6'h00);
    check("oob_no_fire", spike_vec_o, 0);

    // Protocol: start held high gives a sweep every N+1 cycles.
    cfg_write(0, 6'h3F);
    start_i     = 1'b1;
    spikes_in_i = 3'b111;
    c = 0;
    dcount = 0;
    t_prev = 0;
    while (c < 40 && dcount < 3) begin
      @(posedge clk_i);
      #1;
      c++;
      if (done_o) begin
        model_step(3'b111);
        check("held_vec", spike_vec_o, m_vec);
        check("held_cnt", step_cnt_o,  mcnt);
        if (dcount == 0) check("held_first", c, N + 1);
        else             check("held_period", c - t_prev, N + 1);
        t_prev = c;
        dcount++;
        if (dcount == 3) start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    check("held_sweeps", dcount, 3);
    @(posedge clk_i);
    #1;
    check("held_stop", busy_o, 0);

    // Reset mid-sweep at idx=3, with neuron 0 holding a fired flag.
    do_reset();
    cfg_write(0, 6'h3F);
    sweep(3'b111, 0, 0, 0, 6'h00);
    check("pre_abort_fire", spike_vec_o[0], 1);
    start_i     = 1'b1;
    spikes_in_i = 3'b111;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("abort_busy_before", busy_o, 1);
    do_reset();
    // Fresh state: config with the start on the same edge, fires at step 1.
    sweep(3'b111, 0, 1, 0, 6'h3F);
    check("abort_fresh_vec", spike_vec_o, 6'b000001);
    check("abort_fresh_cnt", step_cnt_o,  1);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < N; i++) cfg_write(i, 6'($urandom));
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 3) == 0) cfg_write($urandom_range(0, 7), 6'($urandom));
      sweep(3'($urandom), ($urandom_range(0, 9) == 0), 0, 0, 6'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lif_layer_scheduler.md
Name: lif_layer_scheduler

Overview:
Time-multiplexes one LIF membrane-update datapath across N_NEURON neurons that share the same 3 presynaptic spike inputs. It holds per-neuron membrane state and 2-bit synaptic weights. On each timestep start it sequences neurons 0..N-1, one per clock, and publishes the resulting spike vector atomically. It sits between the timestep generator and the downstream spike router, and replaces N instantiated LIF cells.

Parameters:
N_NEURON, 8, neurons served; 2..256.
AW, $clog2(N_NEURON), config address width.
VW, 5, membrane width in bits.
V_REST, 6, rest/reset potential.
V_LEAK, 1, leak per step, applied only when v > V_REST.
V_TH, 14, firing threshold (fires when v_next >= V_TH).

Ports:
clk_i  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start_i  in  1  timestep request; accepted only when busy_o=0
spikes_in_i  in  3  presynaptic spikes s1..s3 (bit0=s1); sampled on the accepting edge
cfg_we_i  in  1  weight write strobe
cfg_addr_i  in  AW  target neuron index
cfg_w_i  in  6  {w3,w2,w1}, 2 bits each
cfg_err_o  out  1  one-cycle pulse: rejected config write
busy_o  out  1  update sweep in progress
done_o  out  1  one-cycle pulse: spike_vec_o updated
spike_vec_o  out  N_NEURON  spikes of the last completed timestep
step_cnt_o  out  16  completed timesteps, wraps 0xFFFF->0

Behaviour:
- Reset, asynchronous: FSM=IDLE; all membranes=V_REST; all fired flags=0; all weights=0; spike_vec_o=0; busy_o=0; done_o=0; cfg_err_o=0; step_cnt_o=0. Asserting reset mid-sweep aborts the sweep and discards partial results.
- FSM states:
  - IDLE, busy_o=0.
  - RUN, busy_o=1, with index counter idx.
- IDLE to RUN: occurs at edge T0 when start_i=1. spikes_in_i is latched and idx=0.
- RUN: at edge Tk (k=1..N), neuron idx=k-1 is updated and idx increments.
- RUN to IDLE: occurs at edge TN. At that same edge:
  - the staged spike bits are copied into spike_vec_o;
  - step_cnt_o increments;
  - done_o goes high for exactly the cycle after TN;
  - busy_o goes low.
- Latency: start accepted at T0; done_o visible after TN; spike_vec_o is unchanged during RUN.
- Back-to-back operation: start_i=1 while done_o=1 is accepted (FSM is in IDLE). start_i during RUN is ignored and not queued.
- Per-neuron update uses the stored v, fired flag f and weights w1..w3, with latched s:
  - if f=1: v<=V_REST, f<=0, spike=0;
  - else: sum = w1*s1 + w2*s2 + w3*s3 (0..9); vn = v + sum - (v>V_REST ? V_LEAK : 0). vn is computed at VW+2 bits and saturates at 2^VW-1. Then v<=vn, f<=(vn>=V_TH), spike=f.
- A neuron that fires therefore outputs 0 and resets to V_REST on the next timestep. The post-fire value vn is retained until that reset.
- Config, accepted only in IDLE with cfg_addr_i < N_NEURON: weights are written at the edge and used from the next start. A write attempted in RUN or with an out-of-range address is dropped, and cfg_err_o pulses for 1 cycle.
- A config write in the same cycle as an accepted start is applied, and the sweep uses the new weights.
- Config writes do not alter membrane or fired state.

Test Plan:
- Reset then idle: spike_vec_o=0, busy_o=0, step_cnt_o=0. A start pulse gives busy_o=1 for N_NEURON cycles, then done_o pulses exactly once, with spike_vec_o=0 (weights 0) and step_cnt_o=1.
- Neuron 0 weights {3,3,3}, spikes_in_i=3'b111 every step: bit0 across steps 1..4 is 1,0,1,0 (v: 15, 6, 15, 6). Other neurons (weights 0) stay 0.
- Neuron 1 weights {0,0,2}, spikes 3'b001: v per step 8,9,10,11,12,13,14; bit1 fires first at step 7 and is 0 at step 8.
- Neuron 2 weights {0,0,1}, spikes 3'b001: v=7 and stays 7 (leak cancels input); bit2 never fires over 50 steps.
- Protocol checks:
  - cfg write during RUN gives cfg_err_o=1 and weights unchanged;
  - write with address = N_NEURON gives cfg_err_o=1;
  - start_i held high gives a sweep every N_NEURON+1 cycles;
  - start during RUN is ignored.
- Assert rst_n low mid-sweep at idx=3: all outputs return to reset values immediately. The next step matches a fresh-reset run (neuron 0 {3,3,3} fires at step 1).
